// File: rtl/aline_pingpong_writer.sv
// Sweep-synchronous A-line capture writer: on each trigger edge, writes NSAMPLES ADC
// samples into one bank of a ping-pong RAM, then hands that bank to the reader.
module aline_pingpong_writer #(
    parameter int NSAMPLES = 1170,
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 14,
    parameter int SKIP     = 0
) (
    input  logic              ADC_data_out_clk,
    input  logic              global_reset_n,
    input  logic              trigger_in,
    input  logic              enable,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [1:0]        bank_ack,
    output logic              ram_wr_en,
    output logic [ADDR_W:0]   ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [1:0]        bank_ready,
    output logic              acq_busy,
    output logic [15:0]       aline_count,
    output logic [7:0]        overrun_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NSAMPLES - 1);
    localparam logic [7:0]        DLY_INIT = 8'(SKIP - 1);

    logic              trig_s1_q;
    logic              trig_s2_q;
    logic              trig_prev_q;
    logic              edge_q;
    logic [1:0]        ack_sync;
    logic [DATA_W-1:0] d1_q;

    state_t            state_q;
    logic              cur_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        dly_q;
    logic              wr_en_q;
    logic [1:0]        ready_q;
    logic              busy_q;
    logic [15:0]       aline_q;
    logic [7:0]        ovr_q;

    // Trigger: two sync flops, then a registered rising-edge detect.
    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            trig_s1_q   <= trigger_in;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
            edge_q      <= trig_s2_q & ~trig_prev_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ack_sync
        logic s1_q;
        logic s2_q;
        always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
            if (!global_reset_n) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= bank_ack[gi];
                s2_q <= s1_q;
            end
        end
        assign ack_sync[gi] = s2_q;
    end

    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            d1_q <= '0;
        end else begin
            d1_q <= adc_data;
        end
    end

    always_ff @(posedge ADC_data_out_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= IDLE;
            cur_q   <= 1'b0;
            idx_q   <= '0;
            dly_q   <= '0;
            wr_en_q <= 1'b0;
            ready_q <= 2'b00;
            busy_q  <= 1'b0;
            aline_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (ready_q[b] && ack_sync[b]) begin
                    ready_q[b] <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (edge_q && enable) begin
                        // A bank whose ack is still high has not finished its handshake.
                        if (ready_q[cur_q] || ack_sync[cur_q]) begin
                            if (ovr_q != 8'hFF) begin
                                ovr_q <= ovr_q + 8'd1;
                            end
                        end else begin
                            idx_q  <= '0;
                            busy_q <= 1'b1;
                            if (SKIP > 0) begin
                                state_q <= DELAY;
                                dly_q   <= DLY_INIT;
                            end else begin
                                state_q <= CAPTURE;
                                wr_en_q <= 1'b1;
                            end
                        end
                    end
                end

                DELAY: begin
                    if (dly_q == 8'd0) begin
                        state_q <= CAPTURE;
                        wr_en_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - 8'd1;
                    end
                end

                CAPTURE: begin
                    if (idx_q == IDX_LAST) begin
                        wr_en_q        <= 1'b0;
                        ready_q[cur_q] <= 1'b1;
                        cur_q          <= ~cur_q;
                        aline_q        <= aline_q + 16'd1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_wr_en     = wr_en_q;
    assign ram_wr_addr   = {cur_q, idx_q};
    assign ram_wr_data   = d1_q;
    assign bank_ready    = ready_q;
    assign acq_busy      = busy_q;
    assign aline_count   = aline_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_aline_pingpong_writer.sv
// Bench for aline_pingpong_writer: two instances (SKIP=0 and SKIP=5) share stimulus and
// are checked every cycle against a schedule-based model plus hand-computed expectations.
module tb_aline_pingpong_writer;

    localparam int N  = 1170;
    localparam int AW = 11;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trig;
    logic          en;
    logic [DW-1:0] adc;
    logic [1:0]    ack;

    logic          wr_en [2];
    logic [AW:0]   addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    rdy   [2];
    logic          busy  [2];
    logic [15:0]   alc   [2];
    logic [7:0]    ovc   [2];

    always #5 clk = ~clk;

    aline_pingpong_writer #(.NSAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .SKIP(0)) u0 (
        .ADC_data_out_clk(clk), .global_reset_n(rst_n), .trigger_in(trig), .enable(en),
        .adc_data(adc), .bank_ack(ack), .ram_wr_en(wr_en[0]), .ram_wr_addr(addr[0]),
        .ram_wr_data(wdata[0]), .bank_ready(rdy[0]), .acq_busy(busy[0]),
        .aline_count(alc[0]), .overrun_count(ovc[0]));

    aline_pingpong_writer #(.NSAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .SKIP(5)) u1 (
        .ADC_data_out_clk(clk), .global_reset_n(rst_n), .trigger_in(trig), .enable(en),
        .adc_data(adc), .bank_ack(ack), .ram_wr_en(wr_en[1]), .ram_wr_addr(addr[1]),
        .ram_wr_data(wdata[1]), .bank_ready(rdy[1]), .acq_busy(busy[1]),
        .aline_count(alc[1]), .overrun_count(ovc[1]));

    int total = 0;
    int bad   = 0;
    int m     = 0;

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d: got %0h want %0h (edge %0d)", name, inst, act, exp, m);
        end
    endtask

    // Model: a line accepted at edge acc writes during edges acc+skip .. acc+skip+N-1
    // and completes (ready set, bank toggles, count++) at edge acc+skip+N.
    int         skipv [2] = '{0, 5};
    logic       line_m [2];
    int         acc_m  [2];
    logic       cur_m  [2];
    logic [1:0] rdy_m  [2];
    int         alc_m  [2];
    int         ovc_m  [2];
    logic       trig_h [5];
    logic [1:0] ack_h  [3];

    int   nw [2];
    int   fa [2];
    int   la [2];
    int   fe [2];
    int   bc [2];
    logic seen [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            line_m[i] = 1'b0; acc_m[i] = 0; cur_m[i] = 1'b0;
            rdy_m[i] = 2'b00; alc_m[i] = 0; ovc_m[i] = 0;
        end
        for (int k = 0; k < 5; k++) trig_h[k] = 1'b0;
        for (int k = 0; k < 3; k++) ack_h[k] = 2'b00;
    endtask

    initial begin
        logic          det;
        logic          en_s;
        logic [DW-1:0] adc_s;
        logic          exp_we;
        logic          exp_busy;
        logic [AW:0]   exp_addr;
        model_reset();
        forever begin
            @(posedge clk);
            m++;
            if (!rst_n) begin
                model_reset();
                continue;
            end
            for (int k = 4; k > 0; k--) trig_h[k] = trig_h[k-1];
            trig_h[0] = trig;
            for (int k = 2; k > 0; k--) ack_h[k] = ack_h[k-1];
            ack_h[0] = ack;
            en_s  = en;
            adc_s = adc;
            // Edge flag seen by the writer in the previous cycle: trigger rose 3..4 edges ago.
            det = trig_h[3] && !trig_h[4];
            for (int i = 0; i < 2; i++) begin
                for (int b = 0; b < 2; b++)
                    if (rdy_m[i][b] && ack_h[2][b]) rdy_m[i][b] = 1'b0;
                if (line_m[i]) begin
                    if (m == acc_m[i] + skipv[i] + N) begin
                        line_m[i] = 1'b0;
                        rdy_m[i][cur_m[i]] = 1'b1;
                        cur_m[i] = ~cur_m[i];
                        alc_m[i] = (alc_m[i] + 1) % 65536;
                    end
                end else if (det && en_s) begin
                    if (rdy_m[i][cur_m[i]] || ack_h[2][cur_m[i]]) begin
                        if (ovc_m[i] < 255) ovc_m[i]++;
                    end else begin
                        line_m[i] = 1'b1;
                        acc_m[i]  = m;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                exp_we   = line_m[i] && (m >= acc_m[i] + skipv[i]) && (m <= acc_m[i] + skipv[i] + N - 1);
                exp_busy = line_m[i] && (m <= acc_m[i] + skipv[i] + N - 1);
                chk("wr_en", i, wr_en[i], exp_we);
                chk("acq_busy", i, busy[i], exp_busy);
                chk("bank_ready", i, rdy[i], rdy_m[i]);
                chk("aline_count", i, alc[i], alc_m[i]);
                chk("overrun_count", i, ovc[i], ovc_m[i]);
                if (exp_we) begin
                    exp_addr = {cur_m[i], AW'(m - acc_m[i] - skipv[i])};
                    chk("wr_addr", i, addr[i], exp_addr);
                    chk("wr_data", i, wdata[i], adc_s);
                end
                if (wr_en[i]) begin
                    nw[i]++;
                    la[i] = int'(addr[i]);
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        fa[i] = int'(addr[i]);
                        fe[i] = m;
                    end
                end
                if (busy[i]) bc[i]++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        adc = adc + 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            nw[i] = 0; fa[i] = -1; la[i] = -1; fe[i] = -1; bc[i] = 0; seen[i] = 1'b0;
        end
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // One-cycle trigger pulse; returns the edge number that samples it high.
    task automatic pulse(output int tedge);
        @(negedge clk);
        trig  = 1'b1;
        tedge = m + 1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic check_line(input string tag, input int tedge, input int faddr,
                              input logic [1:0] erdy, input int ealc);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_nwrites"}, i, nw[i], N);
            chk({tag, "_first_addr"}, i, fa[i], faddr);
            chk({tag, "_last_addr"}, i, la[i], faddr + N - 1);
            chk({tag, "_first_latency"}, i, fe[i] - tedge, 3 + skipv[i]);
            chk({tag, "_busy_cycles"}, i, bc[i], N + skipv[i]);
            chk({tag, "_ready"}, i, rdy[i], erdy);
            chk({tag, "_aline"}, i, alc[i], ealc);
        end
    endtask

    initial begin
        int te;
        int te2;
        int guard;
        rst_n = 1'b0; trig = 1'b0; en = 1'b0; adc = '0; ack = 2'b00;
        clear_obs();
        wait_neg(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_wr_en", i, wr_en[i], 0);
            chk("rst_ready", i, rdy[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_aline", i, alc[i], 0);
            chk("rst_overrun", i, ovc[i], 0);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        wait_neg(3);

        clear_obs(); pulse(te); wait_neg(N + 30);
        check_line("line1", te, 12'h000, 2'b01, 1);

        clear_obs(); pulse(te); wait_neg(N + 30);
        check_line("line2", te, 12'h800, 2'b11, 2);

        clear_obs(); pulse(te); wait_neg(10);
        for (int i = 0; i < 2; i++) begin
            chk("overrun_nwrites", i, nw[i], 0);
            chk("overrun_count1", i, ovc[i], 1);
            chk("overrun_ready", i, rdy[i], 2'b11);
        end

        @(negedge clk); ack = 2'b01;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("ack_ready_hold", i, rdy[i][0], 1);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("ack_ready_clear", i, rdy[i][0], 0);
        @(negedge clk); ack = 2'b00;
        wait_neg(5);
        clear_obs(); pulse(te); wait_neg(N + 30);
        check_line("line3", te, 12'h000, 2'b11, 3);

        @(negedge clk); ack = 2'b11; wait_neg(5); ack = 2'b00; wait_neg(5);
        for (int i = 0; i < 2; i++) chk("both_freed", i, rdy[i], 2'b00);

        // Line into bank 1 with a stray trigger mid-capture.
        clear_obs(); pulse(te); wait_neg(200); pulse(te2); wait_neg(N + 30);
        check_line("line4", te, 12'h800, 2'b10, 4);
        for (int i = 0; i < 2; i++) chk("midcap_overrun", i, ovc[i], 1);

        // Reset while u0 is writing sample 500 of a bank-0 line.
        clear_obs(); pulse(te);
        guard = 0;
        while (!(wr_en[0] && addr[0][AW-1:0] == AW'(500)) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_idx500", 0, guard < 2000, 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_wr_en", i, wr_en[i], 0);
            chk("midrst_busy", i, busy[i], 0);
            chk("midrst_ready", i, rdy[i], 0);
            chk("midrst_aline", i, alc[i], 0);
            chk("midrst_overrun", i, ovc[i], 0);
        end
        wait_neg(3); rst_n = 1'b1; wait_neg(3);
        clear_obs(); pulse(te); wait_neg(N + 30);
        check_line("post_rst", te, 12'h000, 2'b01, 1);

        clear_obs(); pulse(te); wait_neg(N + 30);
        check_line("fill", te, 12'h800, 2'b11, 2);
        clear_obs();
        for (int k = 0; k < 300; k++) begin
            pulse(te);
            @(negedge clk);
        end
        wait_neg(10);
        for (int i = 0; i < 2; i++) begin
            chk("sat_overrun", i, ovc[i], 255);
            chk("sat_nwrites", i, nw[i], 0);
            chk("sat_ready", i, rdy[i], 2'b11);
            chk("sat_aline", i, alc[i], 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aline_pingpong_writer.md
Name: aline_pingpong_writer

Overview:
- Sweep-synchronous A-line capture writer; the write side of the A-line buffer whose read side is the RAM address counter on clk_system.
- On each sweep trigger edge it writes NSAMPLES consecutive ADC samples into one bank of a two-bank (ping-pong) dual-port RAM.
- It then hands the bank to the reader with a 4-phase ready/ack handshake and switches to the other bank.
- Counts completed A-lines and triggers dropped because no bank was free.

Parameters:
- NSAMPLES, 1170: samples written per A-line.
- ADDR_W, 11: sample address width. Requires NSAMPLES <= 2^ADDR_W.
- DATA_W, 14: ADC sample width.
- SKIP, 0: extra cycles between the detected trigger edge and the first write (0..255).

Ports:
- ADC_data_out_clk  in  1  capture clock; all logic is in this domain.
- global_reset_n  in  1  asynchronous, active-low reset.
- trigger_in  in  1  sweep trigger, asynchronous; captured on its rising edge.
- enable  in  1  arms capture; level.
- adc_data  in  DATA_W  ADC channel A sample.
- bank_ack  in  2  per-bank acknowledge from the reader (clk_system domain).
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  ADDR_W+1  write address: MSB is bank, low bits are sample index.
- ram_wr_data  out  DATA_W  write data.
- bank_ready  out  2  per-bank "line complete, owned by reader".
- acq_busy  out  1  high in DELAY or CAPTURE.
- aline_count  out  16  completed A-lines, wraps at 65535 -> 0.
- overrun_count  out  8  dropped triggers, saturates at 255.

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; current bank 0; sync flops 0. A partial line in progress is discarded, with no ready flag set.
- Trigger path:
  - 2-flop synchronizer followed by an edge register.
  - An edge is detected in cycle T when the synced value is 1 and the previous synced value was 0.
  - Latency from trigger_in rise to detection is 3 clocks.
- bank_ack: each bit passes through its own 2-flop synchronizer.
- adc_data is registered once (d1). ram_wr_data = d1, so each write carries the sample present one clock earlier.
- State machine:
  - IDLE:
    - Edge detected and enable=1 and bank_ready[cur]=0: go to DELAY if SKIP>0, else CAPTURE. Load delay counter = SKIP-1 and sample counter = 0.
    - Edge detected and enable=1 and bank_ready[cur]=1: overrun_count+1 (saturating); stay in IDLE.
    - Edge detected and enable=0: ignored, not counted.
  - DELAY: decrement each cycle; move to CAPTURE on the cycle the counter reads 0.
  - CAPTURE:
    - Every cycle: ram_wr_en=1, ram_wr_addr={cur, idx}, idx increments.
    - idx runs 0..NSAMPLES-1; exactly NSAMPLES writes, no gaps.
    - On the cycle after the write at idx=NSAMPLES-1:
      - ram_wr_en=0.
      - bank_ready[cur] set to 1.
      - cur toggles.
      - aline_count+1.
      - State returns to IDLE.
    - Trigger edges during DELAY or CAPTURE are ignored and not counted.
    - Deasserting enable mid-line does not abort; the line completes.
- Timing from detection: with SKIP=0, the first write is at T+1 and the last at T+NSAMPLES. bank_ready rises at T+NSAMPLES+1.
- Handshake (4-phase, per bank):
  1. Writer raises ready.
  2. Reader raises ack.
  3. Writer clears ready on the first cycle the synced ack=1 while ready=1.
  4. Reader drops ack.
  - The bank is reusable once ready=0.
  - ack=1 while ready=0 is ignored.
  - A bank must not be re-set while its synced ack is still 1. If the writer finds the target bank with ready=0 but synced ack=1 at an edge, treat it as busy and record an overrun.
- acq_busy = (state==DELAY or state==CAPTURE), registered.
- Earliest re-trigger: an edge detected at T+NSAMPLES+1 (IDLE) or later may start the next line into the other bank.

Test Plan:
- Write sequence: reset, enable=1, SKIP=0, adc_data=ramp (+1 per clock), one trigger pulse.
  - Expect 1170 writes at contiguous addresses 0x000..0x491 with data increasing by 1.
  - Expect bank_ready=01 one cycle after the last write, aline_count=1, and acq_busy high for exactly 1170 cycles.
- Ping-pong: second trigger with no acks.
  - Expect writes at 0x800..0xC91 and bank_ready=11.
  - A third trigger gives overrun_count=1, no writes, bank_ready stays 11.
- Handshake: raise bank_ack[0].
  - Expect bank_ready[0] to clear 3 clocks later (2 sync flops plus the clearing register); drop the ack.
  - The next trigger writes bank 0 again.
- Triggers in DELAY/CAPTURE: SKIP=5, plus a trigger pulse mid-capture.
  - Expect the first write 6 clocks after detection.
  - The mid-capture trigger has no effect and overrun_count is unchanged.
- Reset mid-operation: assert global_reset_n low at write idx 500.
  - Expect ram_wr_en=0 immediately and all counters and bank_ready at 0.
  - After release, the next trigger writes from address 0x000.
- Overrun saturation: 300 triggers with both banks full → overrun_count stops at 255.
